set_assoc_cache_ctrl: RTL and testbench

Parametrised N-way set-associative read-allocate / write-through cache controller placed between the CPU memory stage and the SRAM controller. It generalises the two-way, 64-set, 2-word-line cache:
- configurable ways, sets, line length and tag width
- tree pseudo-LRU replacement
- write hits update the cached word in place instead of invalidating the line
- an explicit request/response FSM with registered outputs
- a sweeping flush
- saturating hit/miss counters

---
 rtl/cache_pkg.sv | 52 +++++
 rtl/plru_tree.sv | 23 ++
 rtl/set_assoc_cache_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_set_assoc_cache_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative cache controller:
// FSM state encoding, width helpers and tree pseudo-LRU functions.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RESP  = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int line_w(input int line_words);
    return 32 * line_words;
  endfunction

  function automatic int way_w(input int ways);
    return $clog2(ways);
  endfunction

  // Two ways: the single bit names the victim; touching a way points it at the other.
  function automatic logic plru2_victim(input logic bits);
    return bits;
  endfunction

  function automatic logic plru2_update(input logic way);
    return ~way;
  endfunction

  // Four ways: bit 0 picks the pair (0 = ways 0/1), bit 1 / bit 2 pick within a pair.
  function automatic logic [1:0] plru4_victim(input logic [2:0] bits);
    return bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
  endfunction

  function automatic logic [2:0] plru4_update(input logic [2:0] bits, input logic [1:0] way);
    logic [2:0] nb;
    nb    = bits;
    nb[0] = ~way[1];
    if (!way[1]) nb[1] = ~way[0];
    else         nb[2] = ~way[0];
    return nb;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree pseudo-LRU: victim selection from the current bits and
// the next bits after a given way is touched.
module plru_tree
  import cache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  bits,
  input  logic [WAY_W-1:0] touch_way,
  output logic [WAY_W-1:0] victim,
  output logic [WAYS-2:0]  next_bits
);

  if (WAYS == 2) begin : g_two
    assign victim    = plru2_victim(bits);
    assign next_bits = plru2_update(touch_way);
  end else begin : g_four
    assign victim    = plru4_victim(bits);
    assign next_bits = plru4_update(bits, touch_way);
  end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative read-allocate / write-through cache controller with
// tree PLRU replacement, in-place write-hit update, sweeping flush and counters.
module set_assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 2,
  parameter int TAG_W      = 10,
  parameter int CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       read_en,
  input  logic                       write_en,
  input  logic [31:0]                address,
  input  logic [31:0]                wdata,
  output logic                       ready,
  output logic [31:0]                rdata,
  output logic                       sram_read_en,
  output logic                       sram_write_en,
  output logic [31:0]                sram_address,
  output logic [31:0]                sram_wdata,
  input  logic [32*LINE_WORDS-1:0]   sram_rdata,
  input  logic                       sram_ready,
  input  logic                       flush,
  output logic                       flush_busy,
  output logic [CNT_W-1:0]           hit_count,
  output logic [CNT_W-1:0]           miss_count
);

  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int LINE_W = line_w(LINE_WORDS);
  localparam int WAY_W  = way_w(WAYS);

  state_e               state_q, state_d;
  logic                 pending_q, pending_d;
  logic [IDX_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [31:0]          sram_address_q, sram_address_d;
  logic [31:0]          sram_wdata_q, sram_wdata_d;
  logic [OFF_W-1:0]     req_off_q, req_off_d;
  logic [IDX_W-1:0]     req_idx_q, req_idx_d;
  logic [TAG_W-1:0]     req_tag_q, req_tag_d;
  logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]     miss_cnt_q, miss_cnt_d;

  logic [WAYS-2:0]      plru_q [SETS];

  logic [OFF_W-1:0]     addr_off, lk_off;
  logic [IDX_W-1:0]     addr_idx, lk_idx;
  logic [TAG_W-1:0]     addr_tag, lk_tag;
  logic [WAYS-1:0]      way_hit, way_valid, fill_mask, word_mask;
  logic [LINE_W-1:0]    way_line [WAYS];
  logic [LINE_W-1:0]    hit_line;
  logic [WAY_W-1:0]     hit_way, fill_way, plru_victim, touch_way;
  logic [WAYS-2:0]      plru_cur, plru_next;
  logic                 any_hit, fill_we, word_we, plru_we, flush_clr;
  logic                 unused_addr_lsb;

  assign unused_addr_lsb = ^address[1:0];

  assign addr_off = address[OFF_W+1:2];
  assign addr_idx = address[OFF_W+2 +: IDX_W];
  assign addr_tag = address[OFF_W+2+IDX_W +: TAG_W];

  // In IDLE the live request is looked up; afterwards the latched one is.
  assign lk_off = (state_q == ST_IDLE) ? addr_off : req_off_q;
  assign lk_idx = (state_q == ST_IDLE) ? addr_idx : req_idx_q;
  assign lk_tag = (state_q == ST_IDLE) ? addr_tag : req_tag_q;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic              valid_q [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS];
    logic [LINE_W-1:0] line_q  [SETS];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s < SETS; s++) valid_q[s] <= 1'b0;
      end else if (flush_clr) begin
        valid_q[flush_cnt_q] <= 1'b0;
      end else if (fill_mask[gi]) begin
        valid_q[lk_idx] <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (fill_mask[gi]) begin
        tag_q[lk_idx]  <= lk_tag;
        line_q[lk_idx] <= sram_rdata;
      end else if (word_mask[gi]) begin
        line_q[lk_idx][{lk_off, 5'b0} +: 32] <= sram_wdata_q;
      end
    end

    assign way_valid[gi] = valid_q[lk_idx];
    assign way_hit[gi]   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign way_line[gi]  = line_q[lk_idx];
  end

  assign any_hit  = |way_hit;
  assign hit_line = way_line[hit_way];
  assign plru_cur = plru_q[lk_idx];

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) if (way_hit[w]) hit_way = WAY_W'(w);
  end

  // Lowest-numbered invalid way wins over the PLRU choice.
  always_comb begin
    fill_way = plru_victim;
    for (int w = WAYS - 1; w >= 0; w--) if (!way_valid[w]) fill_way = WAY_W'(w);
  end

  assign touch_way = (state_q == ST_FILL) ? fill_way : hit_way;

  plru_tree #(.WAYS(WAYS), .WAY_W(WAY_W)) u_plru (
    .bits      (plru_cur),
    .touch_way (touch_way),
    .victim    (plru_victim),
    .next_bits (plru_next)
  );

  always_comb begin
    fill_mask = '0;
    if (fill_we) fill_mask[fill_way] = 1'b1;
    word_mask = word_we ? way_hit : '0;
  end

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q | (flush & (state_q != ST_FLUSH));
    flush_cnt_d    = flush_cnt_q;
    rdata_d        = rdata_q;
    sram_address_d = sram_address_q;
    sram_wdata_d   = sram_wdata_q;
    req_off_d      = req_off_q;
    req_idx_d      = req_idx_q;
    req_tag_d      = req_tag_q;
    hit_cnt_d      = hit_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    fill_we        = 1'b0;
    word_we        = 1'b0;
    plru_we        = 1'b0;
    flush_clr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d     = ST_FLUSH;
          pending_d   = 1'b0;
          flush_cnt_d = '0;
        end else if (write_en || read_en) begin
          req_off_d = addr_off;
          req_idx_d = addr_idx;
          req_tag_d = addr_tag;
          if (write_en) begin
            state_d        = ST_WRITE;
            sram_address_d = {address[31:2], 2'b00};
            sram_wdata_d   = wdata;
          end else if (any_hit) begin
            state_d = ST_RESP;
            rdata_d = hit_line[{addr_off, 5'b0} +: 32];
            plru_we = 1'b1;
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
          end else begin
            state_d        = ST_FILL;
            sram_address_d = {address[31:OFF_W+2], {(OFF_W+2){1'b0}}};
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (sram_ready) begin
          fill_we = 1'b1;
          plru_we = 1'b1;
          rdata_d = sram_rdata[{req_off_q, 5'b0} +: 32];
          state_d = ST_RESP;
        end
      end
      ST_WRITE: begin
        if (sram_ready) begin
          word_we = any_hit;
          plru_we = any_hit;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rdata_d = '0;
        state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        flush_clr   = 1'b1;
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == IDX_W'(SETS - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      pending_q      <= 1'b0;
      flush_cnt_q    <= '0;
      rdata_q        <= '0;
      sram_address_q <= '0;
      sram_wdata_q   <= '0;
      req_off_q      <= '0;
      req_idx_q      <= '0;
      req_tag_q      <= '0;
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      flush_cnt_q    <= flush_cnt_d;
      rdata_q        <= rdata_d;
      sram_address_q <= sram_address_d;
      sram_wdata_q   <= sram_wdata_d;
      req_off_q      <= req_off_d;
      req_idx_q      <= req_idx_d;
      req_tag_q      <= req_tag_d;
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (flush_clr) begin
      plru_q[flush_cnt_q] <= '0;
    end else if (plru_we) begin
      plru_q[lk_idx] <= plru_next;
    end
  end

  assign ready         = (state_q == ST_RESP);
  assign sram_read_en  = (state_q == ST_FILL);
  assign sram_write_en = (state_q == ST_WRITE);
  assign flush_busy    = pending_q | (state_q == ST_FLUSH);
  assign rdata         = rdata_q;
  assign sram_address  = sram_address_q;
  assign sram_wdata    = sram_wdata_q;
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench for set_assoc_cache_ctrl: a behavioural SRAM with fixed latency,
// a read-data scoreboard queue, and immediate assertions at every comparison.
module tb_set_assoc_cache_ctrl;

  localparam int WAYS = 2, SETS = 64, LINE_WORDS = 2, TAG_W = 10, CNT_W = 32;

  logic        clk, rst, read_en, write_en, sram_ready, flush;
  logic [31:0] address, wdata, rdata, sram_address, sram_wdata;
  logic [63:0] sram_rdata;
  logic        ready, sram_read_en, sram_write_en, flush_busy;
  logic [CNT_W-1:0] hit_count, miss_count;

  set_assoc_cache_ctrl #(
    .WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
    .address(address), .wdata(wdata), .ready(ready), .rdata(rdata),
    .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .flush(flush), .flush_busy(flush_busy),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  int sram_lat = 3;
  int sram_reads = 0;
  int sram_writes = 0;
  logic [31:0] last_rd_addr = '0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SRAM model: answers any request after sram_lat cycles, records what it saw.
  initial begin
    int  busy_cyc;
    bit  prev_rd, prev_wr;
    busy_cyc   = 0;
    prev_rd    = 0;
    prev_wr    = 0;
    sram_ready = 1'b0;
    sram_rdata = '0;
    forever begin
      @(negedge clk);
      sram_ready = 1'b0;
      if (sram_read_en && !prev_rd) begin
        sram_reads++;
        last_rd_addr = sram_address;
      end
      if (sram_write_en && !prev_wr) begin
        sram_writes++;
        last_wr_addr = sram_address;
        last_wr_data = sram_wdata;
      end
      prev_rd = sram_read_en;
      prev_wr = sram_write_en;
      if (sram_read_en || sram_write_en) begin
        busy_cyc++;
        if (busy_cyc == sram_lat) begin
          busy_cyc   = 0;
          sram_ready = 1'b1;
          if (sram_read_en) sram_rdata = {mem_rd(sram_address + 32'd4), mem_rd(sram_address)};
          else              mem[sram_address] = sram_wdata;
        end
      end else begin
        busy_cyc = 0;
      end
    end
  end

  // Called at a negedge; returns at the negedge where ready was seen.
  task automatic cpu_read(input logic [31:0] a, input bit exp_miss, input int flush_cyc);
    int r0, cyc;
    bit got;
    logic [31:0] exp;
    r0  = sram_reads;
    cyc = 0;
    got = 0;
    exp_q.push_back(mem_rd(a));
    read_en = 1'b1;
    address = a;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      flush = (cyc == flush_cyc);
      if (ready) got = 1;
    end
    flush   = 1'b0;
    read_en = 1'b0;
    exp = exp_q.pop_front();
    if (exp_miss) exp_misses++;
    else          exp_hits++;
    check("rd_ready_seen", 64'(got), 64'd1);
    check("rd_rdata", 64'(rdata), 64'(exp));
    check("rd_sram_reads", 64'(sram_reads - r0), 64'(exp_miss));
    if (exp_miss) check("rd_sram_addr", 64'(last_rd_addr), 64'({a[31:3], 3'b000}));
    else          check("rd_hit_latency", 64'(cyc), 64'd1);
    check("hit_count", 64'(hit_count), 64'(exp_hits));
    check("miss_count", 64'(miss_count), 64'(exp_misses));
    $display("read  addr=%08h rdata=%08h exp=%08h miss=%0d cycles=%0d", a, rdata, exp, exp_miss, cyc);
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    int w0, cyc;
    bit got;
    logic [31:0] exp;
    w0  = sram_writes;
    cyc = 0;
    got = 0;
    exp_q.push_back(32'h0);
    write_en = 1'b1;
    address  = a;
    wdata    = d;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (ready) got = 1;
    end
    write_en = 1'b0;
    exp = exp_q.pop_front();
    check("wr_ready_seen", 64'(got), 64'd1);
    check("wr_rdata_zero", 64'(rdata), 64'(exp));
    check("wr_sram_writes", 64'(sram_writes - w0), 64'd1);
    check("wr_sram_addr", 64'(last_wr_addr), 64'({a[31:2], 2'b00}));
    check("wr_sram_data", 64'(last_wr_data), 64'(d));
    $display("write addr=%08h data=%08h cycles=%0d", a, d, cyc);
  endtask

  initial begin
    int busy_cnt;
    bit side_effect;
    rst = 1'b0; read_en = 1'b0; write_en = 1'b0; flush = 1'b0;
    address = '0; wdata = '0;
    mem[32'h40] = 32'hAAAA_AAAA;
    mem[32'h44] = 32'hBBBB_BBBB;

    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_sram_read_en", 64'(sram_read_en), 64'd0);
    check("rst_sram_write_en", 64'(sram_write_en), 64'd0);
    check("rst_sram_address", 64'(sram_address), 64'd0);
    check("rst_sram_wdata", 64'(sram_wdata), 64'd0);
    check("rst_flush_busy", 64'(flush_busy), 64'd0);
    check("rst_hit_count", 64'(hit_count), 64'd0);
    check("rst_miss_count", 64'(miss_count), 64'd0);
    $display("reset outputs checked");
    rst = 1'b1;
    @(negedge clk);

    // Miss then hit on the same line.
    cpu_read(32'h40, 1, -1);
    @(negedge clk);
    cpu_read(32'h44, 0, -1);
    @(negedge clk);

    // Replacement in set 8 with two ways.
    cpu_read(32'h040, 0, -1);
    @(negedge clk);
    cpu_read(32'h240, 1, -1);
    @(negedge clk);
    cpu_read(32'h040, 0, -1);
    @(negedge clk);
    cpu_read(32'h440, 1, -1);
    @(negedge clk);
    cpu_read(32'h040, 0, -1);
    @(negedge clk);
    cpu_read(32'h240, 1, -1);
    @(negedge clk);

    // Write hit updates in place; write miss does not allocate.
    cpu_write(32'h44, 32'h1234_5678);
    @(negedge clk);
    cpu_read(32'h44, 0, -1);
    @(negedge clk);
    cpu_write(32'h800, 32'hCAFE_F00D);
    @(negedge clk);
    cpu_read(32'h800, 1, -1);
    @(negedge clk);

    // Flush requested during a fill; a read waits behind it.
    cpu_read(32'h1008, 1, 1);
    read_en = 1'b1;
    address = 32'h40;
    busy_cnt = 0;
    side_effect = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!flush_busy) break;
      busy_cnt++;
      if (ready || sram_read_en || sram_write_en) side_effect = 1;
    end
    check("flush_busy_cycles", 64'(busy_cnt), 64'd65);
    check("flush_no_activity", 64'(side_effect), 64'd0);
    $display("flush busy for %0d cycles", busy_cnt);
    cpu_read(32'h40, 1, -1);
    @(negedge clk);

    // Reset in the middle of a fill that the SRAM never answers.
    sram_lat = 1000;
    read_en  = 1'b1;
    address  = 32'h80;
    repeat (2) @(negedge clk);
    check("midfill_sram_read_en", 64'(sram_read_en), 64'd1);
    rst = 1'b0;
    #1;
    check("midrst_sram_read_en", 64'(sram_read_en), 64'd0);
    check("midrst_ready", 64'(ready), 64'd0);
    check("midrst_hit_count", 64'(hit_count), 64'd0);
    check("midrst_miss_count", 64'(miss_count), 64'd0);
    $display("reset asserted mid-fill");
    read_en = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    @(negedge clk);
    rst = 1'b1;
    sram_lat = 3;
    @(negedge clk);
    cpu_read(32'h40, 1, -1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
